// File: rtl/vector_ex_stage.sv
// vector_ex_stage: multi-cycle vector ALU stage, LANES elements per cycle, tail-undisturbed past vl
// Defining VEX_MASK_EN adds the per-element mask port (mask-undisturbed elements).
module vector_ex_stage #(
  parameter int VLEN   = 8,
  parameter int EWIDTH = 32,
  parameter int LANES  = 2,
  parameter int VLW    = $clog2(VLEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               alu_op,
  input  logic [VLW-1:0]           vl,
  input  logic [EWIDTH*VLEN-1:0]   src1,
  input  logic [EWIDTH*VLEN-1:0]   src2,
`ifdef VEX_MASK_EN
  input  logic [VLEN-1:0]          mask,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EWIDTH*VLEN-1:0]   ex_result,
  output logic                     busy
);
  localparam int IW = $clog2(VLEN + LANES + 1);
  localparam int EW = VLEN > 1 ? $clog2(VLEN) : 1;
  localparam int SW = EWIDTH > 1 ? $clog2(EWIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                   r_state, w_next;
  logic [2:0]               r_op;
  logic [IW-1:0]            r_vl, r_idx;
  logic [EWIDTH*VLEN-1:0]   r_src1, r_res, w_res;
  logic [VLEN-1:0]          w_m;
  logic [VLW-1:0]           w_vl;
  logic                     w_go;
  logic [LANES-1:0]         w_wr;
  logic [EW-1:0]            w_sel [LANES];
  logic [EWIDTH-1:0]        w_alu [LANES];

  function automatic logic [EWIDTH-1:0] alu(input logic [2:0] op, input logic [EWIDTH-1:0] a, input logic [EWIDTH-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[SW-1:0];
      3'd6:    return a >> b[SW-1:0];
      default: return ($signed(a) < $signed(b)) ? a : b;
    endcase
  endfunction

  assign w_vl      = (vl > VLW'(VLEN)) ? VLW'(VLEN) : vl;
  assign w_go      = in_valid && r_state == IDLE;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign ex_result = r_res;

  // r_res doubles as the src2 operand store: each element is read before its only write
  always_comb begin
    w_res = r_res;
    for (int j = 0; j < LANES; j++) begin
      w_sel[j] = EW'(r_idx + IW'(j));
      w_wr[j]  = r_state == RUN && (r_idx + IW'(j)) < r_vl && w_m[w_sel[j]];
      w_alu[j] = alu(r_op, r_src1[w_sel[j]*EWIDTH +: EWIDTH], r_res[w_sel[j]*EWIDTH +: EWIDTH]);
      if (w_wr[j]) w_res[w_sel[j]*EWIDTH +: EWIDTH] = w_alu[j];
    end
  end

  always_comb begin
    w_next = r_state == IDLE ? (in_valid ? (w_vl != '0 ? RUN : DONE) : IDLE) :
             r_state == RUN  ? ((r_idx + IW'(LANES) >= r_vl) ? DONE : RUN) :
             (out_ready ? IDLE : DONE);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

`ifdef VEX_MASK_EN
  logic [VLEN-1:0] r_mask;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    r_mask <= '0;
    else if (w_go) r_mask <= mask;
  assign w_m = r_mask;
`else
  assign w_m = '1;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op   <= '0;
      r_vl   <= '0;
      r_idx  <= '0;
      r_src1 <= '0;
      r_res  <= '0;
    end else if (w_go) begin
      r_op   <= alu_op;
      r_vl   <= IW'(w_vl);
      r_idx  <= '0;
      r_src1 <= src1;
      r_res  <= src2;
    end else if (r_state == RUN) begin
      r_idx  <= r_idx + IW'(LANES);
      r_res  <= w_res;
    end
endmodule

// File: tb/tb_vector_ex_stage.sv
// tb_vector_ex_stage: directed vectors; expected results queued at issue, compared by a monitor at each output handshake
module tb_vector_ex_stage;
  logic         clk = 0, rst_n = 1, in_valid = 0, out_ready = 1;
  logic [2:0]   alu_op = 0;
  logic [3:0]   vl = 0;
  logic [255:0] src1 = 0, src2 = 0;
  logic [7:0]   mask = 8'hFF;
  logic         in_ready, out_valid, busy;
  logic [255:0] ex_result;
  logic [255:0] q[$];
  int           n_vec = 0, n_err = 0;

  vector_ex_stage #(.VLEN(8), .EWIDTH(32), .LANES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .vl(vl), .src1(src1), .src2(src2),
`ifdef VEX_MASK_EN
    .mask(mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .ex_result(ex_result), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL result: unexpected output %h", ex_result);
      end else begin
        logic [255:0] e;
        e = q.pop_front();
        if (ex_result !== e) begin
          n_err++;
          $display("FAIL result: got %h expected %h", ex_result, e);
        end
      end
    end

  // element i = m*i + a (mod 2^32)
  function automatic logic [255:0] mk(input logic [31:0] m, input logic [31:0] a);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(i) * m + a;
    return v;
  endfunction

  function automatic logic [255:0] pick(input logic [255:0] a, input logic [255:0] b, input logic [7:0] m);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = m[i] ? a[i*32 +: 32] : b[i*32 +: 32];
    return v;
  endfunction

  task automatic send(input logic [2:0] op, input logic [3:0] v, input logic [255:0] a, input logic [255:0] b,
                      input logic [7:0] m, input logic [255:0] exp);
    int t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("in_ready before issue", in_ready, 1);
    alu_op = op; vl = v; src1 = a; src2 = b; mask = m; in_valid = 1;
    q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(input string name, input int k);
    int n = 0;
    logic ok = 1;
    while (!out_valid && n < 20) begin
      if (!busy || in_ready) ok = 0;
      @(posedge clk); #1; n++;
    end
    if (!busy || in_ready) ok = 0;
    check({name, " latency"}, n, k);
    check({name, " busy"}, ok, 1);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [3:0] v, input logic [255:0] a,
                     input logic [255:0] b, input logic [7:0] m, input logic [255:0] exp, input int k);
    send(op, v, a, b, m, exp);
    wait_out(name, k);
    @(posedge clk); #1;
    check({name, " in_ready"}, in_ready, 1);
  endtask

  task automatic reset_vals(input string name);
    check({name, " in_ready"}, in_ready, 1);
    check({name, " out_valid"}, out_valid, 0);
    check({name, " busy"}, busy, 0);
    check({name, " ex_result"}, ex_result, 0);
  endtask

  initial begin
    logic [255:0] cap;
    logic ok;
    #1 rst_n = 0;
    #11 reset_vals("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    run("add8", 3'd0, 4'd8, mk(1, 0), mk(10, 0), 8'hFF, mk(11, 0), 4);
    run("sub3", 3'd1, 4'd3, mk(0, 100), mk(1, 0), 8'hFF, pick(mk(-1, 100), mk(1, 0), 8'h07), 2);
    run("vl0", 3'd0, 4'd0, mk(1, 0), mk(10, 0), 8'hFF, mk(10, 0), 0);
    run("vl12", 3'd0, 4'd12, mk(1, 0), mk(10, 0), 8'hFF, mk(11, 0), 4);
    run("add5", 3'd0, 4'd5, mk(1, 0), mk(10, 0), 8'hFF, pick(mk(11, 0), mk(10, 0), 8'h1F), 3);
    out_ready = 0;
    send(3'd0, 4'd8, mk(1, 0), mk(10, 0), 8'hFF, mk(11, 0));
    wait_out("bp", 4);
    cap = ex_result;
    alu_op = 3'd1; src1 = mk(0, 7); in_valid = 1;
    ok = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || ex_result !== cap || in_ready) ok = 0;
    end
    check("bp hold", ok, 1);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    check("bp in_ready", in_ready, 1);
    check("bp out_valid", out_valid, 0);
    check("bp busy", busy, 0);
    run("min", 3'd7, 4'd8, mk(0, 32'hFFFFFFFF), mk(0, 1), 8'hFF, mk(0, 32'hFFFFFFFF), 4);
    run("min2", 3'd7, 4'd8, mk(0, 5), mk(0, 32'hFFFFFFFD), 8'hFF, mk(0, 32'hFFFFFFFD), 4);
    run("srl", 3'd6, 4'd8, mk(0, 32'h80000000), mk(0, 33), 8'hFF, mk(0, 32'h40000000), 4);
    run("sll", 3'd5, 4'd8, mk(0, 1), mk(0, 35), 8'hFF, mk(0, 8), 4);
    run("addwrap", 3'd0, 4'd8, mk(0, 32'hFFFFFFFF), mk(0, 1), 8'hFF, mk(0, 0), 4);
    run("and", 3'd2, 4'd8, mk(0, 32'hF0F0F0F0), mk(0, 32'hFF00FF00), 8'hFF, mk(0, 32'hF000F000), 4);
    run("or", 3'd3, 4'd8, mk(0, 32'hF0F0F0F0), mk(0, 32'hFF00FF00), 8'hFF, mk(0, 32'hFFF0FFF0), 4);
    run("xor", 3'd4, 4'd8, mk(0, 32'hF0F0F0F0), mk(0, 32'hFF00FF00), 8'hFF, mk(0, 32'h0FF00FF0), 4);
    alu_op = 3'd0; vl = 4'd8; src1 = mk(1, 0); src2 = mk(10, 0); mask = 8'hFF; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    check("midrun busy", busy, 1);
    rst_n = 0;
    #1 reset_vals("midrun reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    run("after reset", 3'd0, 4'd8, mk(1, 0), mk(10, 0), 8'hFF, mk(11, 0), 4);
`ifdef VEX_MASK_EN
    run("mask55", 3'd0, 4'd8, mk(1, 0), mk(10, 0), 8'h55, pick(mk(11, 0), mk(10, 0), 8'h55), 4);
`endif
    repeat (2) @(posedge clk);
    check("queue drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
